// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator for RV32/RV64 base and RVC formats,
// followed by a small in-order output FIFO that is flushable on mispredict.
module imm_gen_pipe #(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 2,
    parameter int EN_RVC = 1,
    parameter int TAG_W  = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [31:0]      instr_i,
    input  logic [3:0]       sel_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [XLEN-1:0]  imm_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             err_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [3:0] SEL_NONE  = 4'd0;
    localparam logic [3:0] SEL_I     = 4'd1;
    localparam logic [3:0] SEL_I_US  = 4'd2;
    localparam logic [3:0] SEL_S     = 4'd3;
    localparam logic [3:0] SEL_B     = 4'd4;
    localparam logic [3:0] SEL_U     = 4'd5;
    localparam logic [3:0] SEL_J     = 4'd6;
    localparam logic [3:0] SEL_SHAMT = 4'd7;
    localparam logic [3:0] SEL_CSR   = 4'd8;
    localparam logic [3:0] SEL_CI    = 4'd9;
    localparam logic [3:0] SEL_CJ    = 4'd10;
    localparam logic [3:0] SEL_CB    = 4'd11;
    localparam logic [3:0] SEL_CIW   = 4'd12;
    localparam logic [3:0] SEL_CL    = 4'd13;
    localparam logic [3:0] SEL_CSS   = 4'd14;

    logic [XLEN-1:0]  imm_c;
    logic             err_c;
    logic             push;
    logic             pop;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [XLEN-1:0]  imm_mem [DEPTH];
    logic [TAG_W-1:0] tag_mem [DEPTH];
    logic             err_mem [DEPTH];
    logic             unused_bits;

    // The two quadrant bits of a compressed opcode never feed an immediate.
    assign unused_bits = ^instr_i[1:0];

    always_comb begin
        // NOTE: defaults first so every path assigns imm_c/err_c and no latch is inferred.
        imm_c = '0;
        err_c = 1'b0;
        case (sel_i)
            SEL_NONE:  imm_c = '0;
            SEL_I:     imm_c = XLEN'($signed(instr_i[31:20]));
            SEL_I_US:  imm_c = XLEN'(instr_i[31:20]);
            SEL_S:     imm_c = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
            SEL_B:     imm_c = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                              instr_i[11:8], 1'b0}));
            SEL_U:     imm_c = XLEN'($signed({instr_i[31:12], 12'b0}));
            SEL_J:     imm_c = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                              instr_i[30:21], 1'b0}));
            SEL_SHAMT: imm_c = (XLEN == 64) ? XLEN'(instr_i[25:20]) : XLEN'(instr_i[24:20]);
            SEL_CSR:   imm_c = XLEN'(instr_i[19:15]);
            SEL_CI:    imm_c = XLEN'($signed({instr_i[12], instr_i[6:2]}));
            SEL_CJ:    imm_c = XLEN'($signed({instr_i[12], instr_i[8], instr_i[10:9],
                                              instr_i[6], instr_i[7], instr_i[2],
                                              instr_i[11], instr_i[5:3], 1'b0}));
            SEL_CB:    imm_c = XLEN'($signed({instr_i[12], instr_i[6:5], instr_i[2],
                                              instr_i[11:10], instr_i[4:3], 1'b0}));
            SEL_CIW:   imm_c = XLEN'({instr_i[10:7], instr_i[12:11], instr_i[5],
                                      instr_i[6], 2'b0});
            SEL_CL:    imm_c = XLEN'({instr_i[5], instr_i[12:10], instr_i[6], 2'b0});
            SEL_CSS:   imm_c = XLEN'({instr_i[8:7], instr_i[12:9], 2'b0});
            default:   err_c = 1'b1;
        endcase
        // Compressed formats are rejected outright when RVC support is compiled out.
        if ((EN_RVC == 0) && (sel_i >= SEL_CI) && (sel_i <= SEL_CSS)) begin
            imm_c = '0;
            err_c = 1'b1;
        end
    end

    assign ready_o = (count < FULL_CNT);
    assign valid_o = (count != '0);
    assign push    = valid_i && ready_o;
    assign pop     = valid_o && ready_i;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // NOTE: storage is deliberately not reset; count gates every read of it.
    always_ff @(posedge clk_i) begin
        if (push && !flush_i && !rst_i) begin
            imm_mem[wr_ptr] <= imm_c;
            tag_mem[wr_ptr] <= tag_i;
            err_mem[wr_ptr] <= err_c;
        end
    end

    assign imm_o = valid_o ? imm_mem[rd_ptr] : '0;
    assign tag_o = valid_o ? tag_mem[rd_ptr] : '0;
    assign err_o = valid_o ? err_mem[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: a 32-bit/DEPTH=2/RVC instance (a) and a
// 64-bit/DEPTH=3/no-RVC instance (b), checked with immediate assertions.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst;

    logic        flush_a, valid_a, ready_in_a, ready_out_a, vout_a, err_a;
    logic [31:0] instr_a;
    logic [3:0]  sel_a, tag_a, tag_out_a;
    logic [31:0] imm_a;

    logic        flush_b, valid_b, ready_in_b, ready_out_b, vout_b, err_b;
    logic [31:0] instr_b;
    logic [3:0]  sel_b, tag_b, tag_out_b;
    logic [63:0] imm_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .DEPTH(2), .EN_RVC(1), .TAG_W(4)) u_a (
        .clk_i(clk), .rst_i(rst), .flush_i(flush_a), .valid_i(valid_a),
        .ready_o(ready_out_a), .instr_i(instr_a), .sel_i(sel_a), .tag_i(tag_a),
        .valid_o(vout_a), .ready_i(ready_in_a), .imm_o(imm_a), .tag_o(tag_out_a),
        .err_o(err_a)
    );

    imm_gen_pipe #(.XLEN(64), .DEPTH(3), .EN_RVC(0), .TAG_W(4)) u_b (
        .clk_i(clk), .rst_i(rst), .flush_i(flush_b), .valid_i(valid_b),
        .ready_o(ready_out_b), .instr_i(instr_b), .sel_i(sel_b), .tag_i(tag_b),
        .valid_o(vout_b), .ready_i(ready_in_b), .imm_o(imm_b), .tag_o(tag_out_b),
        .err_o(err_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Push one entry into instance a (consumer ready), check the head, then let it drain.
    task automatic fmt_a(input string name, input logic [3:0] sel, input logic [31:0] instr,
                         input logic [31:0] exp_imm, input logic exp_err);
        sel_a = sel; instr_a = instr; tag_a = 4'hA; valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        check({name, "_imm"}, imm_a, exp_imm);
        check({name, "_err"}, err_a, exp_err);
        tick();
    endtask

    task automatic fmt_b(input string name, input logic [3:0] sel, input logic [31:0] instr,
                         input logic [63:0] exp_imm, input logic exp_err);
        sel_b = sel; instr_b = instr; tag_b = 4'h5; valid_b = 1'b1;
        tick();
        valid_b = 1'b0;
        check({name, "_imm"}, imm_b, exp_imm);
        check({name, "_err"}, err_b, exp_err);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        flush_a = 0; valid_a = 0; ready_in_a = 1; instr_a = '0; sel_a = '0; tag_a = '0;
        flush_b = 0; valid_b = 0; ready_in_b = 1; instr_b = '0; sel_b = '0; tag_b = '0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_valid", vout_a, 0);
        check("rst_ready", ready_out_a, 1);
        check("rst_imm", imm_a, 0);
        check("rst_tag", tag_out_a, 0);
        check("rst_err", err_a, 0);
        check("rst_ready_b", ready_out_b, 1);

        // Basic push with one-cycle latency, then drain.
        sel_a = 4'd1; instr_a = 32'hFFF0_0093; tag_a = 4'd3; valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        check("basic_valid", vout_a, 1);
        check("basic_imm", imm_a, 32'hFFFF_FFFF);
        check("basic_tag", tag_out_a, 3);
        check("basic_err", err_a, 0);
        tick();
        check("basic_empty", vout_a, 0);
        check("basic_empty_imm", imm_a, 0);

        // Format sweep on the 32-bit RVC instance.
        fmt_a("none",  4'd0,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
        fmt_a("i_us",  4'd2,  32'hFFF0_0093, 32'h0000_0FFF, 1'b0);
        fmt_a("s_pos", 4'd3,  32'h00A1_2423, 32'h0000_0008, 1'b0);
        fmt_a("s_neg", 4'd3,  32'hFE00_0FA3, 32'hFFFF_FFFF, 1'b0);
        fmt_a("b",     4'd4,  32'hFE00_0EE3, 32'hFFFF_FFFC, 1'b0);
        fmt_a("u32",   4'd5,  32'h8000_00B7, 32'h8000_0000, 1'b0);
        fmt_a("j",     4'd6,  32'h0080_006F, 32'h0000_0008, 1'b0);
        fmt_a("shamt", 4'd7,  32'h01F0_0013, 32'h0000_001F, 1'b0);
        fmt_a("shamt32_top", 4'd7, 32'h03F0_0013, 32'h0000_001F, 1'b0);
        fmt_a("csr",   4'd8,  32'h000F_8000, 32'h0000_001F, 1'b0);
        fmt_a("ci",    4'd9,  32'h0000_10FD, 32'hFFFF_FFFF, 1'b0);
        fmt_a("cj",    4'd10, 32'h0000_1001, 32'hFFFF_F800, 1'b0);
        fmt_a("cj_b5", 4'd10, 32'h0000_0005, 32'h0000_0020, 1'b0);
        fmt_a("cb",    4'd11, 32'h0000_1C01, 32'hFFFF_FF18, 1'b0);
        fmt_a("ciw",   4'd12, 32'h0000_0020, 32'h0000_0008, 1'b0);
        fmt_a("cl",    4'd13, 32'h0000_0020, 32'h0000_0040, 1'b0);
        fmt_a("css",   4'd14, 32'h0000_0180, 32'h0000_00C0, 1'b0);
        fmt_a("ill",   4'd15, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);

        // 64-bit, RVC-disabled instance.
        fmt_b("u64",     4'd5,  32'h8000_00B7, 64'hFFFF_FFFF_8000_0000, 1'b0);
        fmt_b("shamt64", 4'd7,  32'h03F0_0013, 64'h0000_0000_0000_003F, 1'b0);
        fmt_b("i64",     4'd1,  32'hFFF0_0093, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        fmt_b("norvc",   4'd10, 32'h0000_1001, 64'h0, 1'b1);

        // Backpressure on DEPTH=2: third push stalls, head stays stable.
        ready_in_a = 1'b0; sel_a = 4'd1; valid_a = 1'b1;
        instr_a = 32'h0010_0000; tag_a = 4'd1;
        tick();
        check("bp_ready1", ready_out_a, 1);
        instr_a = 32'h0020_0000; tag_a = 4'd2;
        tick();
        check("bp_full", ready_out_a, 0);
        instr_a = 32'h0030_0000; tag_a = 4'd3;
        tick();
        check("bp_stall_ready", ready_out_a, 0);
        check("bp_head_tag", tag_out_a, 1);
        check("bp_head_imm", imm_a, 1);
        ready_in_a = 1'b1;
        tick();
        check("bp_pop1_ready", ready_out_a, 1);
        check("bp_pop1_tag", tag_out_a, 2);
        tick();
        valid_a = 1'b0;
        check("bp_pop2_tag", tag_out_a, 3);
        check("bp_pop2_imm", imm_a, 3);
        tick();
        check("bp_drained", vout_a, 0);

        // Pointer wrap on DEPTH=3.
        ready_in_b = 1'b0; sel_b = 4'd0; valid_b = 1'b1;
        tag_b = 4'd1; tick();
        tag_b = 4'd2; tick();
        tag_b = 4'd3; tick();
        check("wrap_full", ready_out_b, 0);
        valid_b = 1'b0; ready_in_b = 1'b1;
        tick();
        check("wrap_head2", tag_out_b, 2);
        valid_b = 1'b1; tag_b = 4'd4;
        tick();
        check("wrap_head3", tag_out_b, 3);
        tag_b = 4'd5;
        tick();
        check("wrap_head4", tag_out_b, 4);
        valid_b = 1'b0;
        tick();
        check("wrap_head5", tag_out_b, 5);
        tick();
        check("wrap_empty", vout_b, 0);

        // Flush with a concurrent push on DEPTH=3 (ready_o still high).
        ready_in_b = 1'b0; valid_b = 1'b1;
        tag_b = 4'd6; tick();
        tag_b = 4'd7; tick();
        flush_b = 1'b1; tag_b = 4'd9;
        tick();
        flush_b = 1'b0; valid_b = 1'b0;
        check("flush_valid", vout_b, 0);
        check("flush_ready", ready_out_b, 1);
        ready_in_b = 1'b1;
        tick();
        check("flush_no_ghost", vout_b, 0);

        // Flush with a concurrent pop on instance a.
        valid_a = 1'b1; sel_a = 4'd1; instr_a = 32'h0040_0000; tag_a = 4'd4;
        tick();
        valid_a = 1'b0; flush_a = 1'b1;
        tick();
        flush_a = 1'b0;
        check("flush_pop_valid", vout_a, 0);

        // Reset mid-stream with the FIFO full.
        ready_in_a = 1'b0; valid_a = 1'b1;
        tag_a = 4'd6; tick();
        tag_a = 4'd7; tick();
        check("mid_full", ready_out_a, 0);
        valid_a = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", vout_a, 0);
        check("mid_rst_imm", imm_a, 0);
        check("mid_rst_tag", tag_out_a, 0);
        check("mid_rst_err", err_a, 0);
        check("mid_rst_ready", ready_out_a, 1);
        ready_in_a = 1'b1; valid_a = 1'b1; sel_a = 4'd1;
        instr_a = 32'h7FF0_0000; tag_a = 4'd5;
        tick();
        valid_a = 1'b0;
        check("post_rst_valid", vout_a, 1);
        check("post_rst_imm", imm_a, 32'h0000_07FF);
        check("post_rst_tag", tag_out_a, 5);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, buffered immediate generator for the decode stage.
- Extracts and extends immediates from 32-bit base and 16-bit compressed (RVC) instructions to XLEN bits.
- Carries a caller tag through a valid/ready handshake.
- Results pass through a DEPTH-entry in-order output FIFO so decode can run ahead of a stalled issue stage; flushable on branch mispredict.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- DEPTH, 2, output FIFO entries; range 1..8, need not be a power of 2.
- EN_RVC, 1, 1 enables the compressed formats (sel 9..14).
- TAG_W, 4, width of the tag carried alongside each immediate.

Ports:
- clk_i, input, 1: clock.
- rst_i, input, 1: synchronous active-high reset.
- flush_i, input, 1: drop all buffered entries.
- valid_i, input, 1: request valid.
- ready_o, output, 1: request can be accepted.
- instr_i, input, 32: raw instruction; compressed instructions sit in [15:0].
- sel_i, input, 4: format select (encoding below).
- tag_i, input, TAG_W: caller tag.
- valid_o, output, 1: FIFO head valid.
- ready_i, input, 1: consumer accepts head.
- imm_o, output, XLEN: head immediate.
- tag_o, output, TAG_W: head tag.
- err_o, output, 1: head sel was illegal or disabled.

Behaviour:
- Clock and reset: one clock (clk_i); reset is synchronous and active-high (rst_i).
- sel_i encoding. All signed results are sign-extended from their top bit to XLEN.
  - 0 NONE: 0.
  - 1 I: instr[31:20], signed.
  - 2 I_US: instr[31:20], zero-extended.
  - 3 S: {instr[31:25], instr[11:7]}, signed.
  - 4 B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}, signed.
  - 5 U: {instr[31:12], 12'b0}, sign-extended when XLEN=64.
  - 6 J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}, signed.
  - 7 SHAMT: instr[24:20] (XLEN=32) or instr[25:20] (XLEN=64), zero-extended.
  - 8 CSR_UIMM: instr[19:15], zero-extended.
  - 9 CI: {instr[12], instr[6:2]}, signed.
  - 10 CJ: offset[11|4|9:8|10|6|7|3:1|5] = instr[12:2], bit0 = 0, signed.
  - 11 CB: offset[8|4:3] = instr[12:10], offset[7:6|2:1|5] = instr[6:2], signed.
  - 12 CIW: nzuimm[5:4|9:6|2|3] = instr[12:5], zero-extended.
  - 13 CL: uimm[5:3] = instr[12:10], uimm[2|6] = instr[6:5], zero-extended.
  - 14 CSS: uimm[5:2|7:6] = instr[12:7], zero-extended.
  - 15: illegal.
- Errors: sel 15, or sel 9..14 with EN_RVC=0, stores imm = 0 and err = 1. All other sels store err = 0.
- Handshake, push side:
  - Push occurs when valid_i && ready_o at a rising edge.
  - The immediate is computed combinationally and written with the tag and err.
  - ready_o = (count < DEPTH), taken from registered count only.
  - No pass-through when full: a simultaneous pop does not raise ready_o in the same cycle.
- Handshake, pop side:
  - Pop occurs when valid_o && ready_i.
  - valid_o = (count != 0).
  - imm_o, tag_o and err_o come from the head entry.
  - They are driven to 0 when empty and stay stable while valid_o && !ready_i.
- Latency: 1 cycle. Data pushed at edge N is visible at the head after edge N (when the FIFO was empty). Throughput is 1 per cycle.
- Ordering: strict FIFO order.
- Pointers: read and write pointers wrap from DEPTH-1 to 0 (modulo-DEPTH compare, not a power-of-2 mask).
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
- Flush:
  - flush_i at an edge sets count and both pointers to 0.
  - A push or pop in the same cycle is ignored; the flush wins.
  - valid_o = 0 and ready_o = 1 on the next cycle.
- Reset: rst_i takes priority over flush and overrides any operation in progress, including mid-stream. After reset:
  - count = 0, pointers = 0, storage contents don't-care.
  - valid_o = 0, imm_o = 0, tag_o = 0, err_o = 0, ready_o = 1.
- Storage: only the FIFO array, pointers and count are registered; there is no other state.

Test Plan:
- Basic push: after reset, push sel=1, instr=0xFFF00093, tag=3, with ready_i=1 → next cycle valid_o=1, imm_o=0xFFFFFFFF, tag_o=3, err_o=0; FIFO empty the cycle after.
- Format sweep: push sel=4 instr=0xFE000EE3 → 0xFFFFFFFC. Push sel=9 instr=0x000010FD → 0xFFFFFFFF. Push sel=7 instr=0x01F00013 → 0x1F. Push sel=5 instr=0x800000B7, XLEN=64 → 0xFFFFFFFF80000000.
- Backpressure: DEPTH=2, ready_i=0, push tags 1, 2, 3 back-to-back → ready_o low after 2 pushes, tag 3 stalls. Raise ready_i → tags pop in order 1, 2, 3; ready_o never high while count=2. Repeat with DEPTH=3 for pointer wrap.
- Flush: 2 entries buffered, assert flush_i together with valid_i → next cycle valid_o=0, ready_o=1, and the flushed-cycle input never appears.
- Errors: push sel=15 → err_o=1, imm_o=0. With EN_RVC=0, push sel=10 → err_o=1, imm_o=0.
- Reset mid-stream: FIFO full, assert rst_i for 1 cycle → valid_o=0, all outputs 0, ready_o=1. The next push returns correctly with 1-cycle latency.
